// File: rtl/ft_time_sampler_if.sv
// Word stream leaving ft_time_sampler: one 32-bit word per rd_valid/rd_ready handshake.
interface ft_time_sampler_if;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/ft_time_sampler.sv
// Captures snapshots of the four FreezeTime timers into a small FIFO and
// streams each one out as nine 32-bit words (header, then lo/hi of each timer).
module ft_time_sampler #(
    parameter int unsigned SAMPLE_PERIOD = 1024,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    isSim,
    input  logic [63:0]             wallTime,
    input  logic [63:0]             emuTime,
    input  logic [63:0]             simTime,
    input  logic [63:0]             freezeTime,
    input  logic                    snap_req,
    ft_time_sampler_if.master       rd,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    output logic [15:0]             drop_count
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam bit          PER_EN   = (SAMPLE_PERIOD != 0);
    localparam logic [31:0] PER_LAST = PER_EN ? 32'(SAMPLE_PERIOD - 1) : 32'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    localparam logic [1:0] CAUSE_PER = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_END = 2'b11;

    // is_sim records the flag at capture time so the header reflects the trigger cycle.
    typedef struct packed {
        logic [15:0] seq;
        logic [1:0]  cause;
        logic        is_sim;
        logic [63:0] wall;
        logic [63:0] emu;
        logic [63:0] sim;
        logic [63:0] frz;
    } entry_t;

    entry_t         mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [15:0]    seq_q, seq_d, drop_q, drop_d;
    logic           ovf_q, ovf_d, is_sim_q;
    logic [31:0]    period_q, period_d;
    logic [1:0]     state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [31:0]    data_q, data_d;

    logic           trig_end, trig_per, trig, full, push, accept, pop;
    logic [1:0]     cause;
    entry_t         head, new_entry;

    function automatic logic [31:0] word_sel(entry_t e, logic [3:0] i);
        case (i)
            4'd0:    word_sel = {e.seq, 6'b0, e.is_sim, 7'b0, e.cause};
            4'd1:    word_sel = e.wall[31:0];
            4'd2:    word_sel = e.wall[63:32];
            4'd3:    word_sel = e.emu[31:0];
            4'd4:    word_sel = e.emu[63:32];
            4'd5:    word_sel = e.sim[31:0];
            4'd6:    word_sel = e.sim[63:32];
            4'd7:    word_sel = e.frz[31:0];
            default: word_sel = e.frz[63:32];
        endcase
    endfunction

    assign trig_end = is_sim_q & ~isSim;
    assign trig_per = PER_EN & isSim & (period_q == PER_LAST);
    assign trig     = trig_end | snap_req | trig_per;
    assign full     = (count_q == FULL);
    assign push     = trig & ~full;
    assign accept   = (state_q == ST_SEND) & rd.rd_ready;
    assign pop      = accept & (idx_q == 4'd8);
    assign head     = mem_q[rd_ptr_q];

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cause = CAUSE_PER;
        if (trig_end)      cause = CAUSE_END;
        else if (snap_req) cause = CAUSE_SW;

        new_entry.seq    = seq_q;
        new_entry.cause  = cause;
        new_entry.is_sim = isSim;
        new_entry.wall   = wallTime;
        new_entry.emu    = emuTime;
        new_entry.sim    = simTime;
        new_entry.frz    = freezeTime;
    end

    always_comb begin
        period_d = (!isSim || trig_per) ? 32'd0 : period_q + 32'd1;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        seq_d    = push ? seq_q + 16'd1 : seq_q;
        ovf_d    = ovf_q | (trig & full);
        drop_d   = (trig & full & (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        case (state_q)
            // A push in this cycle is enough to start, so word 0 appears two cycles after the trigger.
            ST_IDLE: if (count_q != '0 || push) state_d = ST_LOAD;
            ST_LOAD: begin
                data_d  = word_sel(head, 4'd0);
                idx_d   = 4'd0;
                state_d = ST_SEND;
            end
            ST_SEND: if (accept) begin
                if (idx_q == 4'd8) begin
                    idx_d    = 4'd0;
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    state_d  = (count_q >= (AW+1)'(2)) ? ST_LOAD : ST_IDLE;
                end else begin
                    idx_d  = idx_q + 4'd1;
                    data_d = word_sel(head, idx_q + 4'd1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: snapshot storage has no reset; the pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= new_entry;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            is_sim_q <= 1'b0;
            period_q <= '0;
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            is_sim_q <= isSim;
            period_q <= period_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

    assign rd.rd_valid = (state_q == ST_SEND);
    assign rd.rd_data  = data_q;
    assign fifo_count  = count_q;
    assign overflow    = ovf_q;
    assign drop_count  = drop_q;
endmodule

// File: tb/tb_ft_time_sampler.sv
// Bench for ft_time_sampler: a queue-based snapshot model checks instance A every cycle,
// instance B (periodic sampling off) is checked with directed expectations.
module tb_ft_time_sampler;
    localparam int DEPTH    = 4;
    localparam int A_PERIOD = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [63:0] wall_t = 64'h0000_0010_0000_0100;
    logic [63:0] emu_t, sim_t, frz_t;
    assign emu_t = wall_t * 3;
    assign sim_t = wall_t + 64'h0000_0001_0000_0000;
    assign frz_t = ~wall_t;
    always @(posedge clock) begin
        #1;
        wall_t = wall_t + 64'd1;
    end

    logic        a_isSim = 0, a_snap = 0, b_isSim = 0, b_snap = 0;
    logic [2:0]  a_fifo_count, b_fifo_count;
    logic        a_ovf, b_ovf;
    logic [15:0] a_drop, b_drop;

    ft_time_sampler_if a_if ();
    ft_time_sampler_if b_if ();
    initial begin
        a_if.rd_ready = 1'b0;
        b_if.rd_ready = 1'b0;
    end

    ft_time_sampler #(.SAMPLE_PERIOD(A_PERIOD), .DEPTH(DEPTH)) dut_a (
        .clock(clock), .reset(reset), .isSim(a_isSim),
        .wallTime(wall_t), .emuTime(emu_t), .simTime(sim_t), .freezeTime(frz_t),
        .snap_req(a_snap), .rd(a_if),
        .fifo_count(a_fifo_count), .overflow(a_ovf), .drop_count(a_drop)
    );

    ft_time_sampler #(.SAMPLE_PERIOD(0), .DEPTH(DEPTH)) dut_b (
        .clock(clock), .reset(reset), .isSim(b_isSim),
        .wallTime(wall_t), .emuTime(emu_t), .simTime(sim_t), .freezeTime(frz_t),
        .snap_req(b_snap), .rd(b_if),
        .fifo_count(b_fifo_count), .overflow(b_ovf), .drop_count(b_drop)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] seq;
        logic [1:0]  cause;
        logic        is_sim;
        logic [63:0] wall, emu, sim, frz;
    } snap_t;

    function automatic logic [31:0] exp_word(snap_t s, int i);
        logic [63:0] t;
        if (i == 0) return {s.seq, 6'b0, s.is_sim, 7'b0, s.cause};
        case ((i - 1) / 2)
            0:       t = s.wall;
            1:       t = s.emu;
            2:       t = s.sim;
            default: t = s.frz;
        endcase
        return (i % 2 == 1) ? t[31:0] : t[63:32];
    endfunction

    // Model of instance A: list of held snapshots plus the word position within the head.
    snap_t       m_q[$];
    int          m_idx = 0, m_per = 0, cyc = 0;
    logic        m_sim_q = 0, m_ovf = 0;
    logic [15:0] m_seq = 0, m_drop = 0;
    logic        prev_v = 0, prev_r = 0, prev_rst = 1;
    logic [31:0] prev_d = 0;
    logic [31:0] la_word[$];
    int          la_cyc[$];
    logic [31:0] lb_word[$];

    always @(negedge clock) begin : compare_a
        logic end_t, per_t, trg, full_now, pop_now;
        snap_t s;
        cyc++;
        check("a_fifo_count", a_fifo_count, m_q.size());
        check("a_overflow", a_ovf, m_ovf);
        check("a_drop_count", a_drop, m_drop);
        if (!prev_rst && prev_v && !prev_r) begin
            check("a_hold_valid", a_if.rd_valid, 1);
            check("a_hold_data", a_if.rd_data, prev_d);
        end
        if (m_idx != 0) check("a_valid_mid_snapshot", a_if.rd_valid, 1);
        if (a_if.rd_valid) begin
            if (m_q.size() == 0) check("a_valid_while_empty", a_if.rd_valid, 0);
            else check("a_word", a_if.rd_data, exp_word(m_q[0], m_idx));
        end
        if (a_if.rd_valid && a_if.rd_ready) begin
            la_word.push_back(a_if.rd_data);
            la_cyc.push_back(cyc);
        end
        prev_v   = a_if.rd_valid;
        prev_r   = a_if.rd_ready;
        prev_d   = a_if.rd_data;
        prev_rst = reset;
        if (reset) begin
            m_q.delete();
            m_idx = 0; m_per = 0; m_sim_q = 0; m_ovf = 0; m_seq = 0; m_drop = 0;
        end else begin
            pop_now = 0;
            if (a_if.rd_valid && a_if.rd_ready) begin
                if (m_idx == 8) begin pop_now = 1; m_idx = 0; end
                else m_idx++;
            end
            end_t    = m_sim_q && !a_isSim;
            per_t    = a_isSim && (m_per == A_PERIOD - 1);
            trg      = end_t || a_snap || per_t;
            full_now = (m_q.size() == DEPTH);
            if (trg) begin
                if (full_now) begin
                    m_ovf = 1;
                    if (m_drop != 16'hFFFF) m_drop++;
                end else begin
                    s.seq = m_seq;
                    s.cause = end_t ? 2'b11 : (a_snap ? 2'b10 : 2'b01);
                    s.is_sim = a_isSim;
                    s.wall = wall_t; s.emu = emu_t; s.sim = sim_t; s.frz = frz_t;
                    m_q.push_back(s);
                    m_seq++;
                end
            end
            if (pop_now && m_q.size() > 0) void'(m_q.pop_front());
            m_per   = (!a_isSim || per_t) ? 0 : m_per + 1;
            m_sim_q = a_isSim;
        end
    end

    always @(negedge clock) begin
        if (b_if.rd_valid && b_if.rd_ready) lb_word.push_back(b_if.rd_data);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        step(3);
        check("rst_rd_valid", a_if.rd_valid, 0);
        check("rst_rd_data", a_if.rd_data, 0);
        check("rst_fifo_count", a_fifo_count, 0);
        check("rst_overflow", a_ovf, 0);
        check("rst_drop_count", a_drop, 0);
        reset = 0;
        step(2);

        // Periodic sampling: PER at the 4th and 8th high cycle, END when isSim falls.
        a_if.rd_ready = 1; a_isSim = 1;
        step(10);
        a_isSim = 0;
        step(50);
        check("per_words", la_word.size(), 27);
        if (la_word.size() == 27) begin
            check("per_w0_seq0", la_word[0], 32'h0000_0201);
            check("per_w0_seq1", la_word[9], 32'h0001_0201);
            check("end_w0_seq2", la_word[18], 32'h0002_0003);
            check("per_wall_delta", la_word[10] - la_word[1], 4);
            check("load_bubble", la_cyc[9] - la_cyc[8], 2);
        end

        // Latency: trigger in T, count in T+1, word 0 valid in T+2.
        la_word.delete();
        a_snap = 1; step(1); a_snap = 0;
        check("lat_count_t1", a_fifo_count, 1);
        check("lat_valid_t1", a_if.rd_valid, 0);
        step(1);
        check("lat_valid_t2", a_if.rd_valid, 1);
        check("lat_word0_t2", a_if.rd_data, 32'h0003_0002);
        step(20);

        // SW and PER in the same cycle give one SW snapshot.
        la_word.delete();
        a_isSim = 1; step(3);
        a_snap = 1; step(1);
        a_snap = 0; a_isSim = 0;
        step(40);
        check("swper_words", la_word.size(), 18);
        if (la_word.size() == 18) begin
            check("swper_w0", la_word[0], 32'h0004_0202);
            check("swper_end_w0", la_word[9], 32'h0005_0003);
        end

        // Overflow with backpressure, then drain.
        reset = 1; step(1); reset = 0;
        a_if.rd_ready = 0; a_snap = 1;
        step(6);
        a_snap = 0;
        step(3);
        check("ovf_count", a_fifo_count, 4);
        check("ovf_flag", a_ovf, 1);
        check("ovf_drops", a_drop, 2);
        check("ovf_stall_valid", a_if.rd_valid, 1);
        check("ovf_stall_word", a_if.rd_data, 32'h0000_0002);
        la_word.delete();
        a_if.rd_ready = 1;
        step(45);
        check("drain_words", la_word.size(), 36);
        if (la_word.size() == 36) begin
            for (int k = 0; k < 4; k++)
                check("drain_w0", la_word[9*k], {16'(k), 16'h0002});
            check("drain_wall_delta", la_word[10] - la_word[1], 1);
        end
        check("drain_count", a_fifo_count, 0);

        // Random stalls; hold and ordering are checked by the model every cycle.
        la_word.delete();
        for (int i = 0; i < 120; i++) begin
            a_if.rd_ready = 1'($urandom_range(0, 1));
            a_snap = (i == 0 || i == 5 || i == 30);
            step(1);
        end
        a_snap = 0; a_if.rd_ready = 1;
        step(40);
        check("stall_words", la_word.size(), 27);
        if (la_word.size() == 27) begin
            check("stall_seq4", la_word[0][31:16], 4);
            check("stall_seq5", la_word[9][31:16], 5);
            check("stall_seq6", la_word[18][31:16], 6);
        end

        // Reset while word 4 of a snapshot is presented, with a second entry pending.
        la_word.delete();
        a_snap = 1; step(2); a_snap = 0;
        step(4);
        check("mid_words_before", la_word.size(), 4);
        reset = 1; step(1);
        check("mid_rst_valid", a_if.rd_valid, 0);
        check("mid_rst_count", a_fifo_count, 0);
        check("mid_rst_ovf", a_ovf, 0);
        reset = 0;
        step(3);
        a_snap = 1; step(1); a_snap = 0;
        check("post_rst_count", a_fifo_count, 1);
        step(1);
        check("post_rst_valid", a_if.rd_valid, 1);
        check("post_rst_seq0", a_if.rd_data, 32'h0000_0002);
        step(15);

        // Instance B: no periodic sampling, only END snapshots.
        b_if.rd_ready = 1; b_isSim = 1; step(20);
        b_isSim = 0; step(3);
        b_isSim = 1; step(5);
        b_isSim = 0; step(30);
        check("b_end_words", lb_word.size(), 18);
        if (lb_word.size() == 18) begin
            check("b_end_w0_seq0", lb_word[0], 32'h0000_0003);
            check("b_end_w0_seq1", lb_word[9], 32'h0001_0003);
        end
        check("b_no_drops", b_drop, 0);

        b_if.rd_ready = 0; b_snap = 1;
        step(24);
        check("b_count_full", b_fifo_count, 4);
        check("b_drops_20", b_drop, 20);
        check("b_ovf", b_ovf, 1);
        step(65514);
        check("b_drops_fffe", b_drop, 16'hFFFE);
        step(3);
        check("b_drops_sat", b_drop, 16'hFFFF);
        b_snap = 0;
        step(2);
        check("b_drops_hold", b_drop, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
